// File: rtl/sr32_loader.sv
// sr32_loader
//   Loads a parallel word into the serial shift register (sr32) that drives
//   the divider ratio outputs. A word is accepted over a valid/ready
//   handshake. The register is then cleared and the word is shifted in MSB
//   first. After that the register outputs are re-enabled.
//
// Ports
//   sys_clock, sys_reset_n  clock shared with sr32, async active-low reset
//   load_valid, load_word   load request and word (captured on accept)
//   load_ready              high in IDLE; a load is accepted on valid & ready
//   abort                   cancels a load while it is in CLEAR or SHIFT
//   busy, done, loaded      sequencer status
//   sr_data, sr_enable, sr_reset, sr_output_enable
//                           drive sr32 serdata / serdata_enable /
//                           serdata_reset / output_enable
//
// Every output is decoded from registered state, so no input reaches an
// output combinationally.
module sr32_loader #(
  parameter int unsigned WIDTH         = 32,
  parameter bit          BLANK_ON_LOAD = 1'b1
) (
  input  logic             sys_clock,
  input  logic             sys_reset_n,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_word,
  output logic             load_ready,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             loaded,
  output logic             sr_data,
  output logic             sr_enable,
  output logic             sr_reset,
  output logic             sr_output_enable
);

  localparam int unsigned   CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    SHIFT,
    COMMIT
  } state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] shadow_q;
  logic             loaded_q;

  always_ff @(posedge sys_clock or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      shadow_q <= '0;
      loaded_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          // abort is ignored here; a pending request is still accepted
          if (load_valid) begin
            shadow_q <= load_word;
            state_q  <= CLEAR;
          end
        end
        CLEAR: begin
          if (abort) begin
            state_q  <= IDLE;
            loaded_q <= 1'b0;
          end else begin
            state_q <= SHIFT;
            cnt_q   <= '0;
          end
        end
        SHIFT: begin
          if (abort) begin
            state_q  <= IDLE;
            loaded_q <= 1'b0;
          end else if (cnt_q == LAST) begin
            // loaded is set on entry to COMMIT so that it is already high
            // during the COMMIT cycle, together with done
            state_q  <= COMMIT;
            loaded_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        COMMIT: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign load_ready = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == COMMIT);
  assign loaded     = loaded_q;
  assign sr_reset   = (state_q == CLEAR);
  assign sr_enable  = (state_q == SHIFT);
  assign sr_data    = (state_q == SHIFT) ? shadow_q[LAST - cnt_q] : 1'b0;

  // With blanking on, the outputs are hidden while the register is partially
  // filled. They come back in the COMMIT cycle.
  assign sr_output_enable = loaded_q &
                            (BLANK_ON_LOAD ? ((state_q == IDLE) || (state_q == COMMIT))
                                           : 1'b1);

endmodule

// File: tb/tb_sr32_loader.sv
module tb_sr32_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;

  // 32-bit instance, blanking on load
  logic        load_valid = 1'b0;
  logic [31:0] load_word  = '0;
  logic        abort      = 1'b0;
  logic        load_ready, busy, done, loaded;
  logic        sr_data, sr_enable, sr_reset, sr_output_enable;

  // 8-bit instance, no blanking
  logic        v8 = 1'b0;
  logic [7:0]  w8 = '0;
  logic        ready8, busy8, done8, loaded8;
  logic        data8, en8, rst8, soe8;

  logic [31:0] model32;
  logic [7:0]  model8;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sr32_loader u32 (
    .sys_clock(clk), .sys_reset_n(rst_n),
    .load_valid(load_valid), .load_word(load_word), .load_ready(load_ready),
    .abort(abort), .busy(busy), .done(done), .loaded(loaded),
    .sr_data(sr_data), .sr_enable(sr_enable), .sr_reset(sr_reset),
    .sr_output_enable(sr_output_enable)
  );

  sr32_loader #(.WIDTH(8), .BLANK_ON_LOAD(1'b0)) u8 (
    .sys_clock(clk), .sys_reset_n(rst_n),
    .load_valid(v8), .load_word(w8), .load_ready(ready8),
    .abort(1'b0), .busy(busy8), .done(done8), .loaded(loaded8),
    .sr_data(data8), .sr_enable(en8), .sr_reset(rst8),
    .sr_output_enable(soe8)
  );

  // sr32 behaviour: the register clears on serdata_reset and shifts serdata
  // into the LSB on serdata_enable. The system reset does not clear it.
  always @(posedge clk) begin
    if (sr_reset)       model32 <= '0;
    else if (sr_enable) model32 <= {model32[30:0], sr_data};
    if (rst8)           model8  <= '0;
    else if (en8)       model8  <= {model8[6:0], data8};
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Full load on the 32-bit instance, starting from an IDLE cycle.
  // keep=1 holds load_valid high and presents nw right after the accept.
  task automatic do_load(input logic [31:0] w, input bit keep,
                         input logic [31:0] nw, input string tag);
    logic [31:0] cap;
    bit en_ok, blank_ok;
    load_valid = 1'b1;
    load_word  = w;
    tick();
    abort = 1'b0;
    chk({tag, " clear"}, {28'd0, sr_reset, sr_enable, busy, load_ready}, 32'b1010);
    if (keep) load_word = nw;
    else      load_valid = 1'b0;
    cap = '0; en_ok = 1'b1; blank_ok = 1'b1;
    for (int i = 0; i < 32; i++) begin
      tick();
      cap = {cap[30:0], sr_data};
      if (!(sr_enable && !sr_reset && busy && !load_ready && !done)) en_ok = 1'b0;
      if (sr_output_enable) blank_ok = 1'b0;
    end
    chk({tag, " serial"}, cap, w);
    chk({tag, " shift ctl"}, {31'd0, en_ok}, 32'd1);
    chk({tag, " blank"}, {31'd0, blank_ok}, 32'd1);
    tick();
    chk({tag, " commit"}, {27'd0, done, sr_output_enable, loaded, sr_enable, busy}, 32'b11101);
    chk({tag, " sr32"}, model32, w);
    tick();
    chk({tag, " idle"}, {28'd0, load_ready, busy, done, sr_output_enable}, 32'b1001);
  endtask

  // Load on the 8-bit instance; returns the cycle index of done (accept edge
  // = cycle 0) and whether sr_output_enable was high in cycles 1..10.
  task automatic load8(input logic [7:0] w, output int dcyc, output bit soe_all);
    v8 = 1'b1;
    w8 = w;
    tick();
    v8 = 1'b0;
    dcyc = 0;
    soe_all = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      if (c > 1) tick();
      if (done8 && dcyc == 0) dcyc = c;
      if (!soe8) soe_all = 1'b0;
    end
    tick();
  endtask

  initial begin
    int dcyc;
    bit soe_all;

    // 1: reset applied mid-clock acts before any edge
    #3 rst_n = 1'b0;
    #1;
    chk("reset ready", {31'd0, load_ready}, 32'd1);
    chk("reset outs", {25'd0, busy, done, loaded, sr_data, sr_enable, sr_reset, sr_output_enable}, 32'd0);
    chk("reset 8", {29'd0, ready8, busy8, soe8}, 32'b100);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();
    chk("post reset", {29'd0, load_ready, busy, sr_output_enable}, 32'b100);

    // 2: single load
    do_load(32'hA5A50F0F, 1'b0, 32'h0, "load A5A50F0F");

    // 3: back-to-back with load_valid held; the word changes after the accept
    do_load(32'hFFFFFFFF, 1'b1, 32'h00000001, "load FFFFFFFF");
    do_load(32'h00000001, 1'b0, 32'h0, "load 00000001");

    // 4: abort at cnt=10
    load_valid = 1'b1;
    load_word  = 32'h0F0F0F0F;
    tick();
    load_valid = 1'b0;
    for (int i = 0; i < 11; i++) tick();
    abort = 1'b1;
    tick();
    chk("abort state", {26'd0, load_ready, busy, done, loaded, sr_enable, sr_reset}, 32'b100000);
    chk("abort blank", {31'd0, sr_output_enable}, 32'd0);
    // abort is still high here; in IDLE it must not block the accept
    do_load(32'h12345678, 1'b0, 32'h0, "load 12345678");

    // 5: reset at cnt=20
    load_valid = 1'b1;
    load_word  = 32'h55555555;
    tick();
    load_valid = 1'b0;
    for (int i = 0; i < 21; i++) tick();
    chk("pre reset busy", {30'd0, busy, sr_enable}, 32'b11);
    #2 rst_n = 1'b0;
    #1;
    chk("midload reset", {27'd0, load_ready, busy, sr_enable, loaded, sr_output_enable}, 32'b10000);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    do_load(32'hDEADBEEF, 1'b0, 32'h0, "load DEADBEEF");

    // 6: WIDTH=8, no blanking
    load8(8'h3C, dcyc, soe_all);
    chk("w8 first done cyc", dcyc, 32'd10);
    chk("w8 first sr", {24'd0, model8}, 32'h3C);
    chk("w8 first soe", {30'd0, soe8, ready8}, 32'b11);
    load8(8'hC3, dcyc, soe_all);
    chk("w8 second done cyc", dcyc, 32'd10);
    chk("w8 soe held", {31'd0, soe_all}, 32'd1);
    chk("w8 second sr", {24'd0, model8}, 32'hC3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
